// File: rtl/pcie_dma_credit_pkg.sv
// Shared definitions for the DMA buffered-beat link transmitter: state encoding,
// credit defaults and the counter-width helper.
package pcie_dma_credit_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DEF_CREDITS = 16;

    // Bits needed to hold values 0..val-1.
    function automatic int f_clog2(input int val);
        int r;
        r = 0;
        while ((1 << r) < val) r++;
        return r;
    endfunction

endpackage

// File: rtl/pcie_dma_skid2.sv
// Two-entry valid/ready buffer. Input ready is a flop, so the upstream never
// sees a combinational path from the output side.
module pcie_dma_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_in_data,
    output logic         o_in_ready,
    output logic         o_out_valid,
    output logic [W-1:0] o_out_data,
    input  logic         i_out_ready
);

    logic [W-1:0] r_mem [2];
    logic         r_wr;
    logic         r_rd;
    logic [1:0]   r_cnt;
    logic         r_in_ready;

    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_cnt_nxt;

    assign w_push      = i_in_valid & r_in_ready;
    assign w_pop       = o_out_valid & i_out_ready;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = (r_cnt != 2'd0);
    assign o_out_data  = r_mem[r_rd];

    always_comb begin
        w_cnt_nxt = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_cnt      <= 2'd0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_push) r_wr <= ~r_wr;
            if (w_pop)  r_rd <= ~r_rd;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= (w_cnt_nxt != 2'd2);
        end
    end

    // Payload storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_in_data;
    end

endmodule

// File: rtl/pcie_dma_credit_tx.sv
// Credit-flow-controlled transmitter for the DMA buffered-beat link.
// Optional statistics counters are built when PCIE_CREDIT_TX_STATS_EN is defined.
module pcie_dma_credit_tx
    import pcie_dma_credit_pkg::*;
#(
    parameter  int W       = 8,
    parameter  int CREDITS = DEF_CREDITS,
    localparam int CW      = f_clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          data_in_valid,
    input  logic [W-1:0]  data_in,
    output logic          data_in_ready,
    output logic          tx_valid,
    output logic [W-1:0]  tx_data,
    input  logic          credit_return,
    input  logic          credit_init,
    output logic [CW-1:0] credit_cnt,
    output logic          link_up,
    output logic          ovf_err
`ifdef PCIE_CREDIT_TX_STATS_EN
    ,
    output logic [31:0]   tx_beat_cnt,
    output logic [31:0]   credit_stall_cnt
`endif
);

    localparam logic [CW-1:0] CREDITS_C = CW'(CREDITS);

    state_e        r_state;
    state_e        w_state_nxt;
    logic          w_run;

    logic [CW-1:0] r_credit;
    logic [CW-1:0] w_credit_nxt;
    logic          w_ovf_set;
    logic          r_ovf;

    logic          r_tx_valid;
    logic [W-1:0]  r_tx_data;

    logic          w_skid_in_ready;
    logic          w_skid_valid;
    logic [W-1:0]  w_skid_data;
    logic          w_send;

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_INIT;
        else        r_state <= w_state_nxt;
    end

    // FSM: next state; RUN is only left through reset
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_INIT && credit_init) w_state_nxt = ST_RUN;
    end

    // FSM: outputs
    always_comb begin
        w_run   = (r_state == ST_RUN);
        link_up = w_run;
    end

    pcie_dma_skid2 #(.W(W)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (data_in_valid & w_run),
        .i_in_data   (data_in),
        .o_in_ready  (w_skid_in_ready),
        .o_out_valid (w_skid_valid),
        .o_out_data  (w_skid_data),
        .i_out_ready (w_send)
    );

    assign data_in_ready = w_skid_in_ready & w_run;

    // Only the registered count gates a send; a same-cycle return is not usable yet.
    assign w_send = w_run & w_skid_valid & (r_credit != '0);

    always_comb begin
        w_credit_nxt = r_credit;
        w_ovf_set    = 1'b0;
        if (!w_run) begin
            if (credit_init) w_credit_nxt = CREDITS_C;
        end else if (credit_init) begin
            w_credit_nxt = CREDITS_C - CW'(w_send);
        end else if (credit_return && !w_send) begin
            if (r_credit == CREDITS_C) w_ovf_set    = 1'b1;
            else                       w_credit_nxt = r_credit + 1'b1;
        end else if (!credit_return && w_send) begin
            w_credit_nxt = r_credit - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_credit   <= '0;
            r_ovf      <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= '0;
        end else begin
            r_credit   <= w_credit_nxt;
            r_ovf      <= r_ovf | w_ovf_set;
            r_tx_valid <= w_send;
            if (w_send) r_tx_data <= w_skid_data;
        end
    end

    assign credit_cnt = r_credit;
    assign ovf_err    = r_ovf;
    assign tx_valid   = r_tx_valid;
    assign tx_data    = r_tx_data;

`ifdef PCIE_CREDIT_TX_STATS_EN
    logic [31:0] r_beat_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_cnt  <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_send) r_beat_cnt <= r_beat_cnt + 32'd1;
            if (w_skid_valid && r_credit == '0 && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign tx_beat_cnt      = r_beat_cnt;
    assign credit_stall_cnt = r_stall_cnt;
`endif

endmodule
